pc_fetch_sequencer: RTL

//  Upstream neighbour of the Control/ALU-control decoder: owns the PC, fetches
//  one instruction per iteration from instruction memory over a req/ack

---
 rtl/pc_fetch_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// PC owner and instruction fetch sequencer: fetches over a req/ack handshake,
// holds the instruction for decode/execute, then commits the next PC.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        beq,
  input  logic        bne,
  input  logic        jump,
  input  logic        jr,
  input  logic        jal,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        commit,
  output logic        fault
);

  localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_pc, w_pc_next;
  logic [31:0]   r_instr, w_instr_next;
  logic [CW-1:0] r_cnt, w_cnt_next;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic        w_take_br;
  logic        w_jr_misaligned;
  logic [31:0] w_target;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_br_off        = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_take_br       = (beq & alu_zero) | (bne & ~alu_zero);
  assign w_jr_misaligned = jr & (rs_data[1:0] != 2'b00);

  // jal always arrives with jump from the decoder; OR-ing it in is harmless.
  always_comb begin
    w_target = w_pc_plus4;
    if (jr)
      w_target = rs_data;
    else if (jump | jal)
      w_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    else if (w_take_br)
      w_target = w_pc_plus4 + w_br_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_cnt_next   = r_cnt;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    commit       = 1'b0;
    fault        = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_instr_next = imem_rdata;
          w_cnt_next   = '0;
          w_state_next = S_EXEC;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_FAULT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        // A misaligned jr target retires nothing; the PC stays on the jr.
        if (!stall) begin
          if (w_jr_misaligned) begin
            w_state_next = S_FAULT;
          end else begin
            w_pc_next    = w_target;
            commit       = 1'b1;
            w_state_next = S_FETCH;
          end
        end
      end
      S_FAULT: fault = 1'b1;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign link_addr = w_pc_plus4;

endmodule
